// File: rtl/md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_pkg : shared encodings and defaults for the multiply/divide unit  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_long(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
   endfunction

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_arith : combinational mult/div datapath producing {hi,lo}          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module md_arith
   import md_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_result
);

   logic [63:0] w_a_sx;
   logic [63:0] w_b_sx;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;

   logic        w_b_zero;
   logic        w_a_neg;
   logic        w_b_neg;
   logic        w_ovf;
   logic [31:0] w_b_safe;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_qs_mag;
   logic [31:0] w_rs_mag;
   logic [31:0] w_qs;
   logic [31:0] w_rs;
   logic [31:0] w_qu;
   logic [31:0] w_ru;

   // Low 64 bits of a sign-extended product equal the signed 64-bit product.
   assign w_a_sx   = {{32{i_a[31]}}, i_a};
   assign w_b_sx   = {{32{i_b[31]}}, i_b};
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   assign w_b_zero = (i_b == 32'd0);
   assign w_b_safe = w_b_zero ? 32'd1 : i_b;
   assign w_a_neg  = i_a[31];
   assign w_b_neg  = i_b[31];
   assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

   // Signed divide on magnitudes: quotient truncates toward zero, remainder follows dividend.
   assign w_a_mag  = w_a_neg ? (32'd0 - i_a) : i_a;
   assign w_b_mag  = w_b_neg ? (32'd0 - w_b_safe) : w_b_safe;
   assign w_qs_mag = w_a_mag / w_b_mag;
   assign w_rs_mag = w_a_mag % w_b_mag;
   assign w_qs     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_qs_mag) : w_qs_mag;
   assign w_rs     = w_a_neg ? (32'd0 - w_rs_mag) : w_rs_mag;

   assign w_qu = i_a / w_b_safe;
   assign w_ru = i_a % w_b_safe;

   always_comb begin
      o_result = 64'd0;
      case (i_op)
         MD_MULT:  o_result = w_prod_s;
         MD_MULTU: o_result = w_prod_u;
         MD_DIV: begin
            if (w_b_zero)
               o_result = {i_a, 32'hFFFF_FFFF};
            else if (w_ovf)
               o_result = {32'd0, 32'h8000_0000};
            else
               o_result = {w_rs, w_qs};
         end
         MD_DIVU: begin
            if (w_b_zero)
               o_result = {i_a, 32'hFFFF_FFFF};
            else
               o_result = {w_ru, w_qu};
         end
         default:  o_result = 64'd0;
      endcase
   end

endmodule : md_arith
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_unit : MIPS multiply/divide controller with HI/LO and busy stall   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic [2:0]       r_op;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [63:0]      w_result;

   md_arith u_arith (
      .i_op     (r_op),
      .i_a      (r_a),
      .i_b      (r_b),
      .o_result (w_result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_op    <= 3'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (md_is_long(op)) begin
                     r_op    <= op;
                     r_a     <= a;
                     r_b     <= b;
                     r_cnt   <= md_is_div(op) ? c_DIV_LOAD : c_MULT_LOAD;
                     r_state <= ST_BUSY;
                     r_busy  <= 1'b1;
                  end else if (op == MD_MTHI) begin
                     r_hi <= a;
                  end else if (op == MD_MTLO) begin
                     r_lo <= a;
                  end
               end
            end
            ST_BUSY: begin
               // New starts are ignored here; operands stay as latched.
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_hi    <= w_result[63:32];
                  r_lo    <= w_result[31:0];
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule : md_unit
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_md_unit : directed self-checking bench for md_unit                 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_md_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_tests;
   int n_fail;
   int cyc;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge, then count cycles with busy high (bounded).
   task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         output int n);
      start = 1'b1; op = o; a = va; b = vb;
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
      tick();
      tick();
      reset = 1'b0;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);

      // mult -2 * 3 with an early look at busy and the unchanged HI
      start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFE; b = 32'd3;
      tick();
      start = 1'b0;
      check("mult_busy_first", {63'd0, busy}, 64'd1);
      check("mult_no_bypass", {hi, lo}, 64'd0);
      cyc = 1;
      tick();
      while (busy && cyc < 100) begin
         cyc++;
         tick();
      end
      check("mult_cycles", 64'(cyc), 64'd5);
      check("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
      check("multu_cycles", 64'(cyc), 64'd5);
      check("multu_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});

      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
      check("div_cycles", 64'(cyc), 64'd10);
      check("div_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      run_op(3'd3, 32'd7, 32'd0, cyc);
      check("divu0_cycles", 64'(cyc), 64'd10);
      check("divu0_hilo", {hi, lo}, {32'd7, 32'hFFFF_FFFF});

      run_op(3'd3, 32'd100, 32'd7, cyc);
      check("divu_hilo", {hi, lo}, {32'd2, 32'd14});

      // mthi then mtlo back to back
      start = 1'b1; op = 3'd4; a = 32'h1234_5678;
      tick();
      check("mthi_busy", {63'd0, busy}, 64'd0);
      check("mthi_hilo", {hi, lo}, {32'h1234_5678, 32'd14});
      op = 3'd5; a = 32'h9ABC_DEF0;
      tick();
      check("mtlo_busy", {63'd0, busy}, 64'd0);
      check("mtlo_hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});

      op = 3'd6; a = 32'hDEAD_BEEF;
      tick();
      start = 1'b0;
      check("rsvd_busy", {63'd0, busy}, 64'd0);
      check("rsvd_hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});

      // reset during the 4th busy cycle of a div aborts without commit
      start = 1'b1; op = 3'd2; a = 32'd50; b = 32'd3;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("abort_pre_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hilo", {hi, lo}, 64'd0);
      tick();
      run_op(3'd2, 32'd50, 32'hFFFF_FFFD, cyc);
      check("post_abort_cycles", 64'(cyc), 64'd10);
      check("post_abort_hilo", {hi, lo}, {32'd2, 32'hFFFF_FFF0});

      // div overflow case with a stray start while busy
      start = 1'b1; op = 3'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      tick();
      start = 1'b0;
      cyc = 1;
      tick();
      cyc++;
      start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
      tick();
      start = 1'b0;
      while (busy && cyc < 100) begin
         cyc++;
         tick();
      end
      check("ovf_cycles", 64'(cyc), 64'd10);
      check("ovf_hilo", {hi, lo}, {32'd0, 32'h8000_0000});
      tick();
      tick();
      check("ovf_idle_busy", {63'd0, busy}, 64'd0);
      check("ovf_hold_hilo", {hi, lo}, {32'd0, 32'h8000_0000});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_md_unit
`default_nettype wire
